// File: rtl/timer_display_if.sv
// timer_display_if: counter input and display/status outputs of timer_display
interface timer_display_if;
  logic [6:0] counter;
  logic [6:0] tens_seg;
  logic [6:0] ones_seg;
  logic       busy;
  logic       done;
  logic       warn;
  logic       time_up;
  modport master (output counter, input tens_seg, ones_seg, busy, done, warn, time_up);
  modport slave (input counter, output tens_seg, ones_seg, busy, done, warn, time_up);
endinterface

// File: rtl/timer_display.sv
// timer_display: sequential binary-to-BCD countdown display with warn/time_up flags (optional blink via TIMER_DISPLAY_BLINK_EN)
module timer_display #(
  parameter int unsigned WARN_LEVEL = 10,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input logic        clk,
  input logic        restart,
  timer_display_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CAPTURE, CONV, LOAD} state_t;
  state_t     state_q, state_d;
  logic [6:0] src_q, src_d, last_q, last_d;
  logic [7:0] bcd_q, bcd_d, adj;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] tens_q, tens_d, ones_q, ones_d, tens_seg_q, ones_seg_q;
  logic       busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic       warn_q, warn_d, armed_q, armed_d, time_up_q, time_up_d;
  logic       blank_d;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction
  assign adj = {(bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4],
                (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0]};
  // Next-state: capture on change, 7 shift-add-3 iterations, then load digits and flags
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    last_d    = last_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    warn_d    = warn_q;
    armed_d   = armed_q;
    time_up_d = time_up_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    case (state_q)
      IDLE: state_d = (!valid_q || bus.counter != last_q) ? CAPTURE : IDLE;
      CAPTURE: begin
        src_d   = bus.counter;
        last_d  = bus.counter;
        bcd_d   = 8'd0;
        cnt_d   = 3'd0;
        busy_d  = 1'b1;
        state_d = CONV;
      end
      CONV: begin
        {bcd_d, src_d} = {adj, src_q} << 1;
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd6) ? LOAD : CONV;
      end
      LOAD: begin
        tens_d    = (last_q > 7'd99) ? 7'b0111111 : seg7(bcd_q[7:4]);
        ones_d    = (last_q > 7'd99) ? 7'b0111111 : seg7(bcd_q[3:0]);
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        warn_d    = (last_q != 7'd0) && ({25'd0, last_q} <= WARN_LEVEL);
        armed_d   = armed_q | (last_q != 7'd0);
        time_up_d = time_up_q | (armed_q && last_q == 7'd0);
        state_d   = IDLE;
      end
    endcase
  end
`ifdef TIMER_DISPLAY_BLINK_EN
  logic [31:0] div_q, div_d;
  logic        phase_q, phase_d;
  // Free-running blink divider: phase flips every BLINK_DIV cycles
  always_comb begin
    div_d   = (div_q == BLINK_DIV - 1) ? 32'd0 : div_q + 32'd1;
    phase_d = (div_q == BLINK_DIV - 1) ? ~phase_q : phase_q;
  end
  // Divider state register
  always_ff @(posedge clk) begin
    div_q   <= restart ? 32'd0 : div_d;
    phase_q <= restart ? 1'b0 : phase_d;
  end
  assign blank_d = warn_d & phase_d;
`else
  logic [31:0] unused_blink;
  assign unused_blink = BLINK_DIV;
  assign blank_d = 1'b0;
`endif
  // State and output registers; blanking folds into the segment register so it adds no latency
  always_ff @(posedge clk) begin
    if (restart) begin
      state_q    <= IDLE;
      src_q      <= '0;
      last_q     <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      warn_q     <= 1'b0;
      armed_q    <= 1'b0;
      time_up_q  <= 1'b0;
      tens_q     <= 7'h7F;
      ones_q     <= 7'h7F;
      tens_seg_q <= 7'h7F;
      ones_seg_q <= 7'h7F;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      last_q     <= last_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      warn_q     <= warn_d;
      armed_q    <= armed_d;
      time_up_q  <= time_up_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      tens_seg_q <= blank_d ? 7'h7F : tens_d;
      ones_seg_q <= blank_d ? 7'h7F : ones_d;
    end
  end
  assign bus.tens_seg = tens_seg_q;
  assign bus.ones_seg = ones_seg_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.warn     = warn_q;
  assign bus.time_up  = time_up_q;
endmodule

// File: tb/tb_timer_display.sv
// tb_timer_display: directed self-checking bench for timer_display
module tb_timer_display;
  logic clk = 1'b0;
  logic restart = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  timer_display_if bus();
  timer_display #(.WARN_LEVEL(10), .BLINK_DIV(4)) dut (.clk(clk), .restart(restart), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
  endtask
  task automatic check_val(input string tag, input int v, input logic w);
    check({tag, "_tens"}, bus.tens_seg, segtab[v / 10]);
    check({tag, "_ones"}, bus.ones_seg, segtab[v % 10]);
    check({tag, "_warn"}, bus.warn, w);
  endtask
  initial begin
    bus.counter = 7'd30;
    run(2);
    check("rst_tens", bus.tens_seg, 7'h7F);
    check("rst_ones", bus.ones_seg, 7'h7F);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_warn", bus.warn, 1'b0);
    check("rst_tup", bus.time_up, 1'b0);
    restart = 1'b0;
    done_cnt = 0;
    run(2);
    check("conv_busy", bus.busy, 1'b1);
    check("pre_load_tens", bus.tens_seg, 7'h7F);
    run(8);
    check("p30_tens", bus.tens_seg, 7'b0110000);
    check("p30_ones", bus.ones_seg, 7'b1000000);
    check("p30_done", bus.done, 1'b1);
    check("p30_busy", bus.busy, 1'b0);
    check("p30_tup", bus.time_up, 1'b0);
    run(5);
    check("p30_done_once", done_cnt, 1);
    bus.counter = 7'd12; run(10); check_val("c12", 12, 1'b0);
    bus.counter = 7'd11; run(10); check_val("c11", 11, 1'b0);
    bus.counter = 7'd10; run(9);
    check("c10_warn_before", bus.warn, 1'b0);
    run(1); check_val("c10", 10, 1'b1);
    bus.counter = 7'd9;  run(10); check_val("c9", 9, 1'b1);
    bus.counter = 7'd3;  run(10); check_val("e3", 3, 1'b1);
    bus.counter = 7'd2;  run(10); check_val("e2", 2, 1'b1);
    bus.counter = 7'd1;  run(10); check_val("e1", 1, 1'b1);
    check("e1_tup", bus.time_up, 1'b0);
    bus.counter = 7'd0;  run(9);
    check("e0_tup_before", bus.time_up, 1'b0);
    run(1); check_val("e0", 0, 1'b0);
    check("e0_tup", bus.time_up, 1'b1);
    bus.counter = 7'd60; run(10); check_val("e60", 60, 1'b0);
    check("e60_tup", bus.time_up, 1'b1);
    restart = 1'b1; run(1);
    check("rr_tup", bus.time_up, 1'b0);
    check("rr_tens", bus.tens_seg, 7'h7F);
    restart = 1'b0; run(10); check_val("rr60", 60, 1'b0);
    check("rr60_tup", bus.time_up, 1'b0);
    bus.counter = 7'd90; run(3);
    bus.counter = 7'd45; run(7); check_val("m90", 90, 1'b0);
    run(5);
    check("m_busy2", bus.busy, 1'b1);
    check("m_hold_tens", bus.tens_seg, segtab[9]);
    run(5); check_val("m45", 45, 1'b0);
    check("m45_busy", bus.busy, 1'b0);
    check("m45_done", bus.done, 1'b1);
    bus.counter = 7'd5;   run(10); check_val("o5", 5, 1'b1);
    bus.counter = 7'd105; run(10);
    check("o105_tens", bus.tens_seg, 7'b0111111);
    check("o105_ones", bus.ones_seg, 7'b0111111);
    check("o105_warn", bus.warn, 1'b0);
    bus.counter = 7'd0; restart = 1'b1; run(1);
    restart = 1'b0; run(10); check_val("z0", 0, 1'b0);
    check("z0_tup", bus.time_up, 1'b0);
    run(10);
    check("z0_tup_late", bus.time_up, 1'b0);
`ifdef TIMER_DISPLAY_BLINK_EN
    begin
      int blanks;
      bus.counter = 7'd5; run(12);
      blanks = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (bus.tens_seg == 7'h7F && bus.ones_seg == 7'h7F) blanks++;
      end
      check("blink5_blanks", blanks, 8);
      bus.counter = 7'd20; run(12);
      blanks = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (bus.tens_seg != segtab[2] || bus.ones_seg != segtab[0]) blanks++;
      end
      check("steady20", blanks, 0);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
